axi_line_controller: RTL and testbench
======================================

AXI_LINE_CONTROLLER -- requirements
Module: axi_line_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, giving the cache byte-address width (at most 32).
REQ-002 SHALL have parameter WORDS, default 4, giving the 32-bit words per line (power of two, 2..16).
REQ-003 SHALL have parameter LINE_W, default 32*WORDS, giving the line width (derived, never overridden).
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have req_valid  input  1  line request present.
REQ-007 SHALL have req_ready  output  1  request accepted this cycle; high only in IDLE.
REQ-008 SHALL have req_write  input  1  1 = write line, 0 = read line.
REQ-009 SHALL have req_addr  input  ADDR_W  line address; low log2(4*WORDS) bits ignored.
REQ-010 SHALL have req_wdata  input  LINE_W  write line; word 0 at the MSBs.
REQ-011 SHALL have req_be  input  4*WORDS  byte enables, ordered like req_wdata (word 0 nibble at the MSBs).
REQ-012 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have resp_rdata  output  LINE_W  assembled read line, held until the next read completes.
REQ-014 SHALL have resp_err  output  1  some word got a non-OKAY response; qualified by resp_valid.
REQ-015 SHALL have axi_if  axi4_lite_if.master  --  32-bit AXI4-Lite master (AW, W, B, AR, R).

Function
REQ-016 SHALL accept a request on req_valid && req_ready, capturing base = req_addr with low bits zeroed, plus req_write, req_wdata and req_be.
REQ-017 SHALL use states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE, with word index k (0..WORDS-1) cleared on accept.
REQ-018 SHALL drive all AXI valid/ready outputs as Moore outputs decoded from registered state.
REQ-019 Read: RD_ADDR SHALL assert arvalid with araddr = base + 4*k; on arready go to RD_DATA.
REQ-020 Read: RD_DATA SHALL assert rready; on rvalid store rdata into word k; if k < WORDS-1 then k+1 and RD_ADDR, else DONE.
REQ-021 Write: WR_REQ SHALL assert awvalid and wvalid together with awaddr = base + 4*k, wdata = word k, wstrb = be nibble k.
REQ-022 Write: each of awvalid and wvalid SHALL drop independently after its own handshake; once both are done go to WR_RESP.
REQ-023 Write: WR_RESP SHALL assert bready; on bvalid advance k or go to DONE.
REQ-024 A write word with an all-zero nibble SHALL be skipped with no AXI traffic, costing one WR_REQ cycle.
REQ-025 awaddr/araddr/wdata/wstrb SHALL stay stable while the corresponding valid is high.
REQ-026 At most one transaction SHALL be outstanding; arvalid and awvalid are never high together.
REQ-027 A non-OKAY rresp/bresp SHALL set a sticky error flag; remaining words still transfer and read data is still stored.
REQ-028 DONE SHALL last one cycle with resp_valid=1 and resp_err=flag, then return to IDLE; the flag clears on the next accept.
REQ-029 Latency with a zero-wait slave and no skipped words SHALL be: resp_valid exactly 2*WORDS+1 cycles after the accept edge.
REQ-030 Addresses SHALL be computed in 32 bits, base zero-extended from ADDR_W; a line never crosses its aligned boundary.
REQ-031 req_valid SHALL be ignored outside IDLE.

Reset
REQ-032 While rst_n is low, and immediately on its assertion, the block SHALL be in this state:
- state IDLE, k=0, error flag 0
- all AXI valid/ready outputs 0; awaddr, araddr, wdata, wstrb 0
- resp_valid 0, resp_err 0, resp_rdata 0
- req_ready 1
REQ-033 Reset mid-transaction SHALL abandon the transaction and produce no resp_valid.

Verification
REQ-034 Read, WORDS=4, req_addr 0x0001234, zero-wait slave returning 0x11111111..0x44444444 -> araddr 0x1230/0x1234/0x1238/0x123C; resp_rdata 0x11111111_22222222_33333333_44444444; resp_valid 9 cycles after accept; resp_err 0.
REQ-035 Write, be=0xFFFF, awready one cycle before wready -> awvalid drops after its handshake while wvalid is held; 4 B handshakes; resp_valid with resp_err 0.
REQ-036 Write, be=0x0F0F -> only awaddr base+0x4 and base+0xC issued, each with wstrb 0xF; resp_valid.
REQ-037 Read, rresp=SLVERR on word 2 -> all 4 ARs issued, resp_err=1; a following clean read returns resp_err 0.
REQ-038 rst_n low during RD_DATA of word 1 -> valids/readies 0 immediately, no resp_valid; the next read after reset completes correctly.
REQ-039 WORDS=8 build, read -> araddr base..base+0x1C in order; resp_valid 17 cycles after accept.

Source files
------------

// File: rtl/axi_line_controller_if.sv
// 32-bit AXI4-Lite channel bundle shared by the line controller and its slave.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_line_controller.sv
// Splits a cache-line read/write request into WORDS sequential AXI4-Lite word
// transactions, one outstanding at a time, and reports a single completion.
module axi_line_controller #(
    parameter int ADDR_W = 28,
    parameter int WORDS  = 4,
    parameter int LINE_W = 32*WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [LINE_W-1:0]    req_wdata_i,
    input  logic [4*WORDS-1:0]   req_be_i,
    output logic                 resp_valid_o,
    output logic [LINE_W-1:0]    resp_rdata_o,
    output logic                 resp_err_o,
    axi4_lite_if.master          axi_if
);
    localparam int          KW       = $clog2(WORDS);
    localparam int          OFF_W    = KW + 2;
    localparam logic [31:0] OFF_MASK = 32'((1 << OFF_W) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [31:0]         base_q, base_d;
    logic                write_q, write_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [4*WORDS-1:0]  be_q, be_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [LINE_W-1:0]   resp_rdata_q, resp_rdata_d;

    logic [31:0] k32_s;
    logic [31:0] addr_s;
    logic [31:0] word_s;
    logic [3:0]  nibble_s;
    logic        last_s;
    logic        aw_fin_s;
    logic        w_fin_s;

    // Word k lives at the MSB end of the line; the base is line aligned, so OR is a safe add.
    assign k32_s    = 32'(k_q);
    assign addr_s   = base_q | 32'({k_q, 2'b00});
    assign word_s   = wdata_q[LINE_W-1-32*k32_s -: 32];
    assign nibble_s = be_q[4*WORDS-1-4*k32_s -: 4];
    assign last_s   = (k_q == KW'(WORDS-1));

    assign req_ready_o    = (state_q == IDLE);
    assign resp_valid_o   = resp_valid_q;
    assign resp_err_o     = resp_err_q;
    assign resp_rdata_o   = resp_rdata_q;

    assign axi_if.arvalid = (state_q == RD_ADDR);
    assign axi_if.araddr  = addr_s;
    assign axi_if.rready  = (state_q == RD_DATA);
    assign axi_if.awvalid = (state_q == WR_REQ) && (nibble_s != 4'h0) && !aw_done_q;
    assign axi_if.wvalid  = (state_q == WR_REQ) && (nibble_s != 4'h0) && !w_done_q;
    assign axi_if.awaddr  = addr_s;
    assign axi_if.wdata   = word_s;
    assign axi_if.wstrb   = nibble_s;
    assign axi_if.bready  = (state_q == WR_RESP);

    assign aw_fin_s = aw_done_q | (axi_if.awvalid & axi_if.awready);
    assign w_fin_s  = w_done_q  | (axi_if.wvalid  & axi_if.wready);

    // Next-state and datapath update for the line sequencer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        line_d       = line_q;
        err_d        = err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d   = req_write_i ? WR_REQ : RD_ADDR;
                    k_d       = '0;
                    base_d    = 32'(req_addr_i) & ~OFF_MASK;
                    write_d   = req_write_i;
                    wdata_d   = req_wdata_i;
                    be_d      = req_be_i;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (axi_if.arready) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (axi_if.rvalid) begin
                    line_d[LINE_W-1-32*k32_s -: 32] = axi_if.rdata;
                    err_d   = err_q | (axi_if.rresp != 2'b00);
                    state_d = last_s ? DONE : RD_ADDR;
                    k_d     = last_s ? k_q : k_q + KW'(1);
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_REQ: begin
                if (nibble_s == 4'h0) begin
                    state_d = last_s ? DONE : WR_REQ;
                    k_d     = last_s ? k_q : k_q + KW'(1);
                end else if (aw_fin_s && w_fin_s) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_fin_s;
                    w_done_d  = w_fin_s;
                end
            end
            WR_RESP: begin
                if (axi_if.bvalid) begin
                    err_d   = err_q | (axi_if.bresp != 2'b00);
                    state_d = last_s ? DONE : WR_REQ;
                    k_d     = last_s ? k_q : k_q + KW'(1);
                end else begin
                    state_d = WR_RESP;
                end
            end
            DONE: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                if (!write_q) begin
                    resp_rdata_d = line_q;
                end else begin
                    resp_rdata_d = resp_rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops every AXI valid/ready at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            base_q       <= 32'h0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            line_q       <= '0;
            err_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            line_q       <= line_d;
            err_q        <= err_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_line_controller.sv
// Directed plus randomized bench for axi_line_controller against a memory slave
// and a line-level reference model.
module tb_axi_line_controller;
    localparam int W   = 4;
    localparam int LW  = 32*W;
    localparam int W8  = 8;
    localparam int LW8 = 32*W8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_write = 1'b0, req_ready, resp_valid, resp_err;
    logic [27:0]     req_addr = '0;
    logic [LW-1:0]   req_wdata = '0, resp_rdata;
    logic [4*W-1:0]  req_be = '0;
    logic            req8_valid = 1'b0, req8_ready, resp8_valid, resp8_err;
    logic [27:0]     req8_addr = '0;
    logic [LW8-1:0]  resp8_rdata;

    axi4_lite_if ax();
    axi4_lite_if ax8();

    axi_line_controller #(.ADDR_W(28), .WORDS(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .axi_if(ax));

    axi_line_controller #(.ADDR_W(28), .WORDS(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req8_valid), .req_ready_o(req8_ready),
        .req_write_i(1'b0), .req_addr_i(req8_addr), .req_wdata_i({LW8{1'b0}}), .req_be_i({(4*W8){1'b0}}),
        .resp_valid_o(resp8_valid), .resp_rdata_o(resp8_rdata), .resp_err_o(resp8_err), .axi_if(ax8));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW8-1:0] got, input logic [LW8-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory slave for the main instance ----------------
    bit          zw = 1'b1, aw_first = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    bit          rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0, w_only_seen = 1'b0, proto_bad = 1'b0;
    logic [31:0] rd_addr, aw_a, w_d;
    logic [3:0]  w_s;
    logic [31:0] ar_log[$], aw_log[$];
    logic [3:0]  ws_log[$];
    int          b_cnt = 0;
    bit          p_arv, p_arhs, p_awv, p_awhs, p_wv, p_whs;
    logic [31:0] p_ara, p_awa, p_wd;
    logic [3:0]  p_ws;

    function automatic logic [31:0] seed(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : seed(a);
    endfunction
    function automatic logic [31:0] rref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed(a);
    endfunction
    function automatic bit coin();
        return ($urandom_range(0, 1) == 1);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ax.arready = 1'b0; ax.rvalid = 1'b0; ax.rdata = 32'h0; ax.rresp = 2'b00;
            ax.awready = 1'b0; ax.wready = 1'b0; ax.bvalid = 1'b0; ax.bresp = 2'b00;
            rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        end else begin
            ax.arready = ax.arvalid && !rd_pend && (zw || coin());
            ax.rvalid  = rd_pend && (zw || coin());
            ax.rdata   = ax.rvalid ? mrd(rd_addr) : 32'h0;
            ax.rresp   = (ax.rvalid && rd_addr == err_addr) ? 2'b10 : 2'b00;
            ax.awready = ax.awvalid && !aw_got && (zw || coin());
            ax.wready  = ax.wvalid && !w_got && (aw_first ? aw_got : (zw || coin()));
            ax.bvalid  = aw_got && w_got && (zw || coin());
            ax.bresp   = (ax.bvalid && aw_a == err_addr) ? 2'b10 : 2'b00;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            p_arv = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_arhs = 1'b0; p_awhs = 1'b0; p_whs = 1'b0;
        end else begin
            if (ax.arvalid && ax.awvalid) proto_bad = 1'b1;
            if (p_arv && !p_arhs && !(ax.arvalid && ax.araddr == p_ara)) proto_bad = 1'b1;
            if (p_awv && !p_awhs && !(ax.awvalid && ax.awaddr == p_awa)) proto_bad = 1'b1;
            if (p_wv && !p_whs && !(ax.wvalid && ax.wdata == p_wd && ax.wstrb == p_ws)) proto_bad = 1'b1;
            p_arv = ax.arvalid; p_arhs = ax.arready; p_ara = ax.araddr;
            p_awv = ax.awvalid; p_awhs = ax.awready; p_awa = ax.awaddr;
            p_wv = ax.wvalid; p_whs = ax.wready; p_wd = ax.wdata; p_ws = ax.wstrb;
            if (ax.wvalid && !ax.awvalid) w_only_seen = 1'b1;
            if (ax.arvalid && ax.arready) begin
                ar_log.push_back(ax.araddr); rd_pend = 1'b1; rd_addr = ax.araddr;
            end
            if (ax.rvalid && ax.rready) rd_pend = 1'b0;
            if (ax.awvalid && ax.awready) begin
                aw_log.push_back(ax.awaddr); aw_got = 1'b1; aw_a = ax.awaddr;
            end
            if (ax.wvalid && ax.wready) begin
                ws_log.push_back(ax.wstrb); w_got = 1'b1; w_d = ax.wdata; w_s = ax.wstrb;
            end
            if (ax.bvalid && ax.bready) begin
                logic [31:0] v;
                v = mrd(aw_a);
                for (int b = 0; b < 4; b++) if (w_s[b]) v[8*b +: 8] = w_d[8*b +: 8];
                mem[aw_a] = v;
                b_cnt++; aw_got = 1'b0; w_got = 1'b0;
            end
        end
    end

    // ---------------- zero-wait read-only slave for the 8-word instance ----------------
    bit          rp8 = 1'b0;
    logic [31:0] ra8;
    logic [31:0] ar8_log[$];

    always @(negedge clk) begin
        ax8.arready = ax8.arvalid && !rp8;
        ax8.rvalid  = rp8;
        ax8.rdata   = rp8 ? (ra8 ^ 32'hC0DE_0000) : 32'h0;
        ax8.rresp   = 2'b00;
        ax8.awready = 1'b0; ax8.wready = 1'b0; ax8.bvalid = 1'b0; ax8.bresp = 2'b00;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ax8.arvalid && ax8.arready) begin
                ar8_log.push_back(ax8.araddr); rp8 = 1'b1; ra8 = ax8.araddr;
            end else if (ax8.rvalid && ax8.rready) begin
                rp8 = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_aw[$];

    function automatic logic [31:0] base_of(input logic [27:0] a);
        return {4'h0, a} & ~32'(4*W - 1);
    endfunction

    function automatic logic [LW-1:0] line_ref(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < W; i++) l[LW-1-32*i -: 32] = rref(base + 32'(4*i));
        return l;
    endfunction

    // Applies a line write to ref_mem; returns zero-wait latency and expected AW list.
    task automatic model_write(input logic [31:0] base, input logic [LW-1:0] wd,
                               input logic [4*W-1:0] be, output int lat);
        logic [3:0]  nib;
        logic [31:0] word, v;
        exp_aw.delete();
        lat = 1;
        for (int i = 0; i < W; i++) begin
            nib  = be[4*W-1-4*i -: 4];
            word = wd[LW-1-32*i -: 32];
            lat += (nib == 4'h0) ? 1 : 2;
            if (nib != 4'h0) begin
                exp_aw.push_back(base + 32'(4*i));
                v = rref(base + 32'(4*i));
                for (int b = 0; b < 4; b++) if (nib[b]) v[8*b +: 8] = word[8*b +: 8];
                ref_mem[base + 32'(4*i)] = v;
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic [27:0] addr, input logic [LW-1:0] wd,
                          input logic [4*W-1:0] be, output int lat, output logic [LW-1:0] rd,
                          output logic err);
        int t;
        ar_log.delete(); aw_log.delete(); ws_log.delete(); b_cnt = 0; w_only_seen = 1'b0;
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        lat = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = c; break; end
        end
        chk("resp_seen", lat != 0, 1);
        rd = resp_rdata; err = resp_err;
        @(posedge clk); #1;
        chk("resp_pulse", resp_valid, 0);
    endtask

    initial begin
        int            lat, elat;
        logic [LW-1:0] rd, wd;
        logic [15:0]   be;
        logic          err;
        logic [31:0]   base;
        logic [27:0]   a;
        int            nz;

        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
        chk("rst_vld", {ax.arvalid, ax.awvalid, ax.wvalid, ax.rready, ax.bready}, 0);
        chk("rst_bus", {ax.araddr, ax.awaddr, ax.wdata, ax.wstrb}, 0);
        rst_n = 1'b1;

        // Directed zero-wait read with known data.
        for (int i = 0; i < 4; i++) begin
            mem[32'h1230 + 32'(4*i)]     = {8{4'(i + 1)}};
            ref_mem[32'h1230 + 32'(4*i)] = {8{4'(i + 1)}};
        end
        do_req(1'b0, 28'h0001234, '0, '0, lat, rd, err);
        chk("rd_lat", lat, 9);
        chk("rd_data", rd, 128'h11111111_22222222_33333333_44444444);
        chk("rd_err", err, 0);
        chk("rd_ar_cnt", ar_log.size(), 4);
        for (int i = 0; i < ar_log.size(); i++) chk("rd_araddr", ar_log[i], 32'h1230 + 32'(4*i));

        // Full write with awready leading wready.
        aw_first = 1'b1;
        wd = {$urandom, $urandom, $urandom, $urandom};
        model_write(32'h2000, wd, 16'hFFFF, elat);
        do_req(1'b1, 28'h0002008, wd, 16'hFFFF, lat, rd, err);
        aw_first = 1'b0;
        chk("wr_b_cnt", b_cnt, 4);
        chk("wr_w_only", w_only_seen, 1);
        chk("wr_err", err, 0);
        for (int i = 0; i < aw_log.size(); i++) chk("wr_awaddr", aw_log[i], exp_aw[i]);

        // Sparse write skips all-zero nibbles.
        wd = {$urandom, $urandom, $urandom, $urandom};
        model_write(32'h3000, wd, 16'h0F0F, elat);
        do_req(1'b1, 28'h0003000, wd, 16'h0F0F, lat, rd, err);
        chk("skip_lat", lat, elat);
        chk("skip_aw_cnt", aw_log.size(), 2);
        if (aw_log.size() == 2) begin
            chk("skip_aw0", aw_log[0], 32'h3004);
            chk("skip_aw1", aw_log[1], 32'h300C);
        end else begin
            chk("skip_aw_list", aw_log.size(), 2);
        end
        for (int i = 0; i < ws_log.size(); i++) chk("skip_wstrb", ws_log[i], 4'hF);
        do_req(1'b0, 28'h0003000, '0, '0, lat, rd, err);
        chk("skip_readback", rd, line_ref(32'h3000));
        do_req(1'b0, 28'h0002000, '0, '0, lat, rd, err);
        chk("full_readback", rd, line_ref(32'h2000));

        // SLVERR on word 2 is sticky for the line only.
        err_addr = 32'h4008;
        do_req(1'b0, 28'h0004000, '0, '0, lat, rd, err);
        chk("slverr_ar_cnt", ar_log.size(), 4);
        chk("slverr_err", err, 1);
        chk("slverr_data", rd, line_ref(32'h4000));
        err_addr = 32'hFFFF_FFFF;
        do_req(1'b0, 28'h0005000, '0, '0, lat, rd, err);
        chk("clean_err", err, 0);

        // Reset during RD_DATA of word 1.
        ar_log.delete();
        @(negedge clk);
        req_write = 1'b0; req_addr = 28'h0006000; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 0; t < 50 && !(ar_log.size() == 2 && ax.rready); t++) @(negedge clk);
        chk("rst_mid_reached", ar_log.size() == 2 && ax.rready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", {ax.arvalid, ax.awvalid, ax.wvalid, ax.rready, ax.bready}, 0);
        chk("rst_mid_ready", req_ready, 1);
        nz = 0;
        repeat (3) begin @(posedge clk); #1; if (resp_valid) nz++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (resp_valid) nz++; end
        chk("rst_mid_no_resp", nz, 0);
        do_req(1'b0, 28'h0006000, '0, '0, lat, rd, err);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_data", rd, line_ref(32'h6000));

        // Eight-word instance read.
        @(negedge clk);
        req8_addr = 28'h0001104; req8_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req8_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (resp8_valid) begin lat = c; break; end
        end
        chk("w8_lat", lat, 17);
        chk("w8_ar_cnt", ar8_log.size(), 8);
        for (int i = 0; i < ar8_log.size(); i++) chk("w8_araddr", ar8_log[i], 32'h1100 + 32'(4*i));
        begin
            logic [LW8-1:0] l8;
            for (int i = 0; i < W8; i++) l8[LW8-1-32*i -: 32] = (32'h1100 + 32'(4*i)) ^ 32'hC0DE_0000;
            chk("w8_data", resp8_rdata, l8);
        end

        // Random write/read-back with a random-wait slave.
        zw = 1'b0;
        for (int it = 0; it < 10; it++) begin
            a    = 28'($urandom);
            base = base_of(a);
            wd   = {$urandom, $urandom, $urandom, $urandom};
            be   = 16'($urandom);
            model_write(base, wd, be, elat);
            do_req(1'b1, a, wd, be, lat, rd, err);
            chk("rnd_wr_err", err, 0);
            chk("rnd_aw_cnt", aw_log.size(), exp_aw.size());
            for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++) chk("rnd_awaddr", aw_log[i], exp_aw[i]);
            do_req(1'b0, a, '0, '0, lat, rd, err);
            chk("rnd_rd_data", rd, line_ref(base));
            chk("rnd_rd_err", err, 0);
        end

        chk("axi_protocol", proto_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
